// File: rtl/debounce_multi.sv
// N-channel switch debouncer: 2-flop sync, saturating stability counter, rise/fall pulses; DEBOUNCE_HOLD_EN adds long-press pulse.
// Latency: input change before edge k shows on o_Switch at edge k+1+c_DEBOUNCE_LIMIT; no backpressure (free-running).
module debounce_multi #(
    parameter int c_NUM_CH         = 4,
    parameter int c_DEBOUNCE_LIMIT = 250000,
    parameter bit c_RESET_LEVEL    = 1'b0,
    parameter int c_HOLD_LIMIT     = 25000000
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic [c_NUM_CH-1:0] i_Switch,
    output logic [c_NUM_CH-1:0] o_Switch,
    output logic [c_NUM_CH-1:0] o_Rise,
    output logic [c_NUM_CH-1:0] o_Fall,
    output logic [c_NUM_CH-1:0] o_Hold
);

    localparam int CNT_W = $clog2(c_DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(c_DEBOUNCE_LIMIT - 1);

    if (c_NUM_CH < 1) begin : g_bad_num_ch
        $error("debounce_multi: c_NUM_CH must be >= 1");
    end
    if (c_DEBOUNCE_LIMIT < 2) begin : g_bad_limit
        $error("debounce_multi: c_DEBOUNCE_LIMIT must be >= 2");
    end
    if (c_HOLD_LIMIT < 1) begin : g_bad_hold
        $error("debounce_multi: c_HOLD_LIMIT must be >= 1");
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int HOLD_W = $clog2(c_HOLD_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(c_HOLD_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(c_HOLD_LIMIT - 1);
`endif

    for (genvar n = 0; n < c_NUM_CH; n++) begin : g_ch
        logic             s1;
        logic             s2;
        logic [CNT_W-1:0] cnt;
        logic             sw_q;
        logic             rise_q;
        logic             fall_q;

        // Sync flops reset to the debounced level so release never looks like a change.
        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                s1     <= c_RESET_LEVEL;
                s2     <= c_RESET_LEVEL;
                cnt    <= '0;
                sw_q   <= c_RESET_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                s1     <= i_Switch[n];
                s2     <= s1;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s2 == sw_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt    <= '0;
                    sw_q   <= s2;
                    rise_q <= s2;
                    fall_q <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign o_Switch[n] = sw_q;
        assign o_Rise[n]   = rise_q;
        assign o_Fall[n]   = fall_q;

`ifdef DEBOUNCE_HOLD_EN
        logic [HOLD_W-1:0] hold_cnt;
        logic              hold_q;

        // Saturates at the limit so the long-press pulse fires once per press.
        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                hold_cnt <= '0;
                hold_q   <= 1'b0;
            end else begin
                hold_q <= 1'b0;
                if (!sw_q) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    hold_q   <= (hold_cnt == HOLD_PRE);
                end
            end
        end

        assign o_Hold[n] = hold_q;
`else
        assign o_Hold[n] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

    localparam int NCH  = 4;
    localparam int LIM  = 4;
    localparam int HOLD = 8;
    localparam int LAT  = LIM + 2;  // steps from an input change (just after an edge) to the pulse

    logic           i_Clk = 1'b0;
    logic           i_Rst_n;
    logic [NCH-1:0] i_Switch;
    logic [NCH-1:0] o_Switch;
    logic [NCH-1:0] o_Rise;
    logic [NCH-1:0] o_Fall;
    logic [NCH-1:0] o_Hold;

    always #5 i_Clk = ~i_Clk;

    debounce_multi #(
        .c_NUM_CH        (NCH),
        .c_DEBOUNCE_LIMIT(LIM),
        .c_RESET_LEVEL   (1'b0),
        .c_HOLD_LIMIT    (HOLD)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Rise  (o_Rise),
        .o_Fall  (o_Fall),
        .o_Hold  (o_Hold)
    );

    typedef struct {
        int             cyc;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] hold;
    } ev_t;

    typedef struct {
        logic [NCH-1:0] sw;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
    } vec_t;

    ev_t            sb[$];
    vec_t           tbl[7];
    int             cyc   = 0;
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [NCH-1:0] exp_sw = '0;

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // Schedule an expected pulse LAT steps after the change just driven.
    task automatic expect_ev(input logic [NCH-1:0] r, input logic [NCH-1:0] f);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.rise = r;
        e.fall = f;
        e.hold = '0;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] r, input logic [NCH-1:0] f);
        i_Switch = v;
        if ((r | f) != '0) expect_ev(r, f);
    endtask

    task automatic step();
        logic [NCH-1:0] er;
        logic [NCH-1:0] ef;
        logic [NCH-1:0] eh;
        @(posedge i_Clk);
        #1;
        cyc++;
        er = '0;
        ef = '0;
        eh = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                er |= sb[i].rise;
                ef |= sb[i].fall;
                eh |= sb[i].hold;
                sb.delete(i);
            end
        end
        exp_sw = (exp_sw | er) & ~ef;
`ifdef DEBOUNCE_HOLD_EN
        for (int i = 0; i < sb.size(); i++) sb[i].hold = sb[i].hold & ~ef;
        if (er != '0) begin
            ev_t e;
            e.cyc  = cyc + HOLD;
            e.rise = '0;
            e.fall = '0;
            e.hold = er;
            sb.push_back(e);
        end
`endif
        check("o_Switch", o_Switch, exp_sw);
        check("o_Rise", o_Rise, er);
        check("o_Fall", o_Fall, ef);
        check("o_Hold", o_Hold, eh);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        tbl[0] = '{sw: 4'b0000, rise: 4'b0000, fall: 4'b1111};
        tbl[1] = '{sw: 4'b0001, rise: 4'b0001, fall: 4'b0000};
        tbl[2] = '{sw: 4'b0110, rise: 4'b0110, fall: 4'b0001};
        tbl[3] = '{sw: 4'b0110, rise: 4'b0000, fall: 4'b0000};
        tbl[4] = '{sw: 4'b1110, rise: 4'b1000, fall: 4'b0000};
        tbl[5] = '{sw: 4'b0111, rise: 4'b0001, fall: 4'b1000};
        tbl[6] = '{sw: 4'b0000, rise: 4'b0000, fall: 4'b0111};

        // Reset with all switches pressed: nothing may leak out while held or just after release.
        i_Rst_n  = 1'b0;
        i_Switch = 4'b1111;
        #1;
        check("rst_switch", o_Switch, 4'b0000);
        check("rst_rise", o_Rise, 4'b0000);
        check("rst_fall", o_Fall, 4'b0000);
        check("rst_hold", o_Hold, 4'b0000);
        steps(3);
        i_Rst_n = 1'b1;
        expect_ev(4'b1111, 4'b0000);
        steps(LAT + 2);

        // Table: clean presses/releases, held-stable row, simultaneous rise+fall across channels.
        for (int v = 0; v < 7; v++) begin
            drive(tbl[v].sw, tbl[v].rise, tbl[v].fall);
            steps(10);
        end

        // Bounce on ch2 every 2 cycles, then settle high: one rise only.
        drive(4'b0100, 4'b0000, 4'b0000); steps(2);
        drive(4'b0000, 4'b0000, 4'b0000); steps(2);
        drive(4'b0100, 4'b0000, 4'b0000); steps(2);
        drive(4'b0000, 4'b0000, 4'b0000); steps(2);
        drive(4'b0100, 4'b0100, 4'b0000); steps(LAT + 4);

        // ch1 holds new level LIM-1 cycles, one-cycle glitch back, then settles: full latency restarts.
        drive(4'b0110, 4'b0000, 4'b0000); steps(LIM - 1);
        drive(4'b0100, 4'b0000, 4'b0000); steps(1);
        drive(4'b0110, 4'b0010, 4'b0000); steps(LAT + 4);

        drive(4'b0000, 4'b0000, 4'b0110); steps(10);

        // Reset mid-count on ch1: count discarded, full latency again after release.
        drive(4'b0010, 4'b0000, 4'b0000); steps(2);
        #2;
        i_Rst_n = 1'b0;
        #1;
        check("midrst_switch", o_Switch, 4'b0000);
        check("midrst_rise", o_Rise, 4'b0000);
        sb.delete();
        exp_sw = '0;
        steps(2);
        i_Rst_n = 1'b1;
        expect_ev(4'b0010, 4'b0000);
        steps(LAT + 3);

        // Long press on ch0, release, press again (hold pulses only in the hold build).
        drive(4'b0011, 4'b0001, 4'b0000); steps(20);
        drive(4'b0010, 4'b0000, 4'b0001); steps(10);
        drive(4'b0011, 4'b0001, 4'b0000); steps(20);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain got=%0d want=0 pending events", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
